axis_isif_fifo: RTL and testbench
=================================

# axis_isif_fifo

Input-stream front end for `core`. It accepts an AXI4-Stream slave beat stream (tdata/tstrb/tlast/tuser with valid/ready) from the DMA and buffers it in a small register FIFO. It presents the buffered beats on the FIFO-style `isif` interface (`empty_n`/`read`) that `core` consumes. It also counts completed packets for host-side debug.

## Interface
Parameters:
- `TRANS_BITS`, 64, data width in bits; must equal `TRANS_BYTE_SIZE*8`.
- `TRANS_BYTE_SIZE`, 8, number of strobe bits.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `ADDR_BITS`, 4, log2(`DEPTH`).

Ports:
- `clk` in 1: clock; all logic is rising-edge.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `s_axis_tdata` in `TRANS_BITS`: upstream data.
- `s_axis_tstrb` in `TRANS_BYTE_SIZE`: byte strobes.
- `s_axis_tlast` in 1: last beat of packet.
- `s_axis_tuser` in 1: sideband, stored as-is.
- `s_axis_tvalid` in 1: upstream beat valid.
- `s_axis_tready` out 1: FIFO can accept a beat (registered).
- `dout_isif_data` out `TRANS_BITS`: head-of-FIFO data.
- `dout_isif_strb` out `TRANS_BYTE_SIZE`: head strobes.
- `dout_isif_last` out 1: head tlast.
- `dout_isif_user` out 1: head tuser.
- `dout_isif_empty_n` out 1: head entry valid.
- `din_isif_read` in 1: consumer pops the head this cycle.
- `fifo_count` out `ADDR_BITS+1`: occupancy, 0..`DEPTH`.
- `pkt_cnt` out 16: number of accepted beats with tlast=1; wraps at 65535→0.

## Operation
- Push: `s_axis_tvalid && s_axis_tready`. Writes {data, strb, last, user} to `mem[wr_ptr]` and increments `wr_ptr` (mod `DEPTH`).
- Pop: `din_isif_read && dout_isif_empty_n`. Increments `rd_ptr` (mod `DEPTH`). A read while `empty_n`=0 is ignored; there is no underflow.
- First-word fall-through: `dout_isif_*` = `mem[rd_ptr]` combinationally. The head is valid whenever `empty_n`=1.
- `fifo_count` is updated as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop occur together, or when neither occurs.
- `empty_n` = (`fifo_count` != 0), registered.
- `s_axis_tready` next = (`count_next` != `DEPTH`). Because this is computed from the next count, a pop in the same cycle that the FIFO becomes full reopens ready on the next cycle.
- No push can occur when full, since ready is 0. Simultaneous push+pop at count `DEPTH`−1 or 1 behaves as above.
- `pkt_cnt` increments on every push with tlast=1, independent of pops.
- Pointers wrap naturally via `ADDR_BITS`-wide counters. The full/empty decision comes from `fifo_count` only.
- Bytes are not swapped here; endian conversion stays in `core`.

## Timing
- Reset values:
  - `s_axis_tready`=0.
  - `empty_n`=0.
  - `fifo_count`=0.
  - `pkt_cnt`=0.
  - Pointers=0.
  - All `mem` entries=0, so `dout_isif_*`=0.
- First cycle after reset deasserts: `s_axis_tready`=1.
- Push-to-visible latency is 1 cycle. A beat accepted at edge N gives `empty_n`=1 with that beat on `dout_isif_*` after edge N. The consumer may pop it in that cycle, with the pop taking effect at edge N+1.
- Throughput is 1 beat/cycle in and out simultaneously at any non-boundary occupancy.
- Reset asserted mid-packet behaves as follows:
  - Contents, pointers and `pkt_cnt` are discarded at that edge.
  - `tready` is 0 while reset is held.
  - Upstream beats presented during reset are not accepted.
- `tvalid` must not depend on `tready`. This block never drops an accepted beat.

## Configuration
- `ISIF_STRB_MASK_EN` defined: on push, each data byte whose `tstrb` bit is 0 is stored as 8'h00. Strobes are stored unchanged.
- Not defined: data is stored unmodified regardless of `tstrb`.

## Test plan
- Reset, then single beat data=64'h0123_4567_89AB_CDEF, strb=8'hFF, last=1, user=1 → `empty_n`=1 one cycle later with identical outputs; `pkt_cnt`=1; read → `empty_n`=0, `fifo_count`=0.
- Fill test, no reads: 16 beats (data=0..15) accepted → `tready`=0 and `fifo_count`=16 after the 16th push. A 17th beat held valid is not accepted until one read; then the 17th beat is accepted the cycle after `tready` returns to 1. Read-out order is 0..16.
- Continuous streaming: tvalid=1 and read=1 for 100 cycles with incrementing data → `fifo_count` stays ≤1, no beat lost or duplicated, order preserved.
- Pointer wrap: 40 beats with random tvalid/read gaps → output sequence equals input sequence; `pkt_cnt` equals the number of tlast beats sent (e.g. last every 8th beat → 5).
- Reset mid-packet with `fifo_count`=5 → next cycle `fifo_count`=0, `empty_n`=0, `pkt_cnt`=0, `dout_isif_data`=0; `tready`=1 the cycle after reset drops.
- With `ISIF_STRB_MASK_EN`: data=64'hFFFF_FFFF_FFFF_FFFF, strb=8'h0F → output 64'h0000_0000_FFFF_FFFF; without the macro, output is all ones.

Source files
------------

// File: rtl/axis_isif_fifo.sv
// axis_isif_fifo: AXI4-Stream slave beats buffered in a first-word-fall-through register FIFO, presented on the isif pop interface
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   s_axis_t*             AXI4-Stream slave (tdata/tstrb/tlast/tuser/tvalid in, tready out, registered)
//   dout_isif_*           head-of-FIFO data/strb/last/user, empty_n flags a valid head
//   din_isif_read         consumer pops the head this cycle (ignored while empty)
//   fifo_count            occupancy 0..DEPTH
//   pkt_cnt               accepted beats with tlast=1, wraps at 16 bits
//
// Optional build macro ISIF_STRB_MASK_EN: data bytes whose tstrb bit is 0 are stored as 8'h00.
module axis_isif_fifo #(
    parameter int TRANS_BITS      = 64,
    parameter int TRANS_BYTE_SIZE = 8,
    parameter int DEPTH           = 16,
    parameter int ADDR_BITS       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [TRANS_BITS-1:0]      s_axis_tdata,
    input  logic [TRANS_BYTE_SIZE-1:0] s_axis_tstrb,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tuser,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [TRANS_BITS-1:0]      dout_isif_data,
    output logic [TRANS_BYTE_SIZE-1:0] dout_isif_strb,
    output logic                       dout_isif_last,
    output logic                       dout_isif_user,
    output logic                       dout_isif_empty_n,
    input  logic                       din_isif_read,
    output logic [ADDR_BITS:0]         fifo_count,
    output logic [15:0]                pkt_cnt
);
    localparam int EW = TRANS_BITS + TRANS_BYTE_SIZE + 2;
    localparam logic [ADDR_BITS:0] FULL = (ADDR_BITS + 1)'(DEPTH);

    if (TRANS_BITS != TRANS_BYTE_SIZE * 8) begin : g_bad_width
        $error("TRANS_BITS must equal TRANS_BYTE_SIZE*8");
    end
    if (DEPTH < 2 || DEPTH != (1 << ADDR_BITS)) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2 equal to 2**ADDR_BITS");
    end

    logic [EW-1:0]              mem_q [DEPTH];
    logic [EW-1:0]              mem_d [DEPTH];
    logic [ADDR_BITS-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]         count_q, count_d;
    logic                       empty_n_q, empty_n_d;
    logic                       tready_q, tready_d;
    logic [15:0]                pkt_cnt_q, pkt_cnt_d;
    logic [TRANS_BITS-1:0]      wdata;
    logic                       push, pop;

    assign push = s_axis_tvalid && tready_q;
    assign pop  = din_isif_read && empty_n_q;

    always_comb begin
        wdata = s_axis_tdata;
`ifdef ISIF_STRB_MASK_EN
        for (int i = 0; i < TRANS_BYTE_SIZE; i++)
            wdata[i*8 +: 8] = s_axis_tstrb[i] ? s_axis_tdata[i*8 +: 8] : 8'h00;
`endif
    end

    // Ready and empty_n are derived from the next count so both are registered
    // yet reflect this cycle's push/pop one edge later.
    always_comb begin
        mem_d = mem_q;
        if (push)
            mem_d[wr_ptr_q] = {wdata, s_axis_tstrb, s_axis_tlast, s_axis_tuser};
        wr_ptr_d  = push ? wr_ptr_q + ADDR_BITS'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + ADDR_BITS'(1) : rd_ptr_q;
        count_d   = (push && !pop) ? count_q + (ADDR_BITS + 1)'(1) :
                    (pop && !push) ? count_q - (ADDR_BITS + 1)'(1) : count_q;
        empty_n_d = count_d != '0;
        tready_d  = count_d != FULL;
        pkt_cnt_d = (push && s_axis_tlast) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_n_q <= 1'b0;
            tready_q  <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_n_q <= empty_n_d;
            tready_q  <= tready_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign {dout_isif_data, dout_isif_strb, dout_isif_last, dout_isif_user} = mem_q[rd_ptr_q];
    assign dout_isif_empty_n = empty_n_q;
    assign s_axis_tready     = tready_q;
    assign fifo_count        = count_q;
    assign pkt_cnt           = pkt_cnt_q;
endmodule

// File: tb/tb_axis_isif_fifo.sv
// tb_axis_isif_fifo: scoreboard bench for axis_isif_fifo with directed vectors
module tb_axis_isif_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tstrb = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] dout_isif_data;
    logic [7:0]  dout_isif_strb;
    logic        dout_isif_last;
    logic        dout_isif_user;
    logic        dout_isif_empty_n;
    logic        din_isif_read = 1'b0;
    logic [4:0]  fifo_count;
    logic [15:0] pkt_cnt;

    int chk = 0;
    int errs = 0;
    int rd_mode = 0;
    bit streaming = 1'b0;
    int max_cnt = 0;
    logic [73:0] exp_q [$];

    axis_isif_fifo dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .dout_isif_data(dout_isif_data), .dout_isif_strb(dout_isif_strb),
        .dout_isif_last(dout_isif_last), .dout_isif_user(dout_isif_user),
        .dout_isif_empty_n(dout_isif_empty_n), .din_isif_read(din_isif_read),
        .fifo_count(fifo_count), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        chk++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    // Called at a negedge; inputs are sampled at the next posedge, and since
    // tready is registered its value now decides acceptance at that edge.
    task automatic send(input logic [63:0] d, input logic [7:0] s, input logic l,
                        input logic u, input logic [63:0] ed);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tstrb  = s;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", s_axis_tready, 1);
        if (s_axis_tready) exp_q.push_back({ed, s, l, u});
        @(negedge clk);
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rd_mode = 1;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        check("drain_count", fifo_count, 0);
        check("drain_empty_n", dout_isif_empty_n, 0);
        rd_mode = 0;
    endtask

    // Monitor: decides the read strobe just after each negedge and compares the
    // head against the scoreboard whenever a pop will take effect.
    initial begin
        logic rd;
        forever begin
            @(negedge clk);
            #1;
            rd = (rd_mode == 1) || (rd_mode == 3) || (rd_mode == 2 && $urandom_range(0, 1) == 1);
            if (rd_mode == 3) rd_mode = 0;
            din_isif_read = rd;
            if (streaming && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (rd && dout_isif_empty_n) begin
                if (exp_q.size() == 0) begin
                    chk++;
                    errs++;
                    $display("FAIL pop_unexpected got=%0h required=none", dout_isif_data);
                end else begin
                    check("pop_head", {dout_isif_data, dout_isif_strb, dout_isif_last, dout_isif_user},
                          exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tready", s_axis_tready, 0);
        check("rst_empty_n", dout_isif_empty_n, 0);
        check("rst_count", fifo_count, 0);
        check("rst_pkt", pkt_cnt, 0);
        check("rst_data", dout_isif_data, 0);
        reset = 1'b0;
        @(negedge clk);
        check("tready_after_rst", s_axis_tready, 1);

        send(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
        idle();
        check("single_empty_n", dout_isif_empty_n, 1);
        check("single_data", dout_isif_data, 64'h0123_4567_89AB_CDEF);
        check("single_strb", dout_isif_strb, 8'hFF);
        check("single_last", dout_isif_last, 1);
        check("single_user", dout_isif_user, 1);
        check("single_pkt", pkt_cnt, 1);
        rd_mode = 3;
        @(negedge clk);
        check("single_empty_after_read", dout_isif_empty_n, 0);
        check("single_count_after_read", fifo_count, 0);

        for (int i = 0; i < 16; i++) send(64'(i), 8'hFF, 1'b0, 1'b0, 64'(i));
        check("full_tready", s_axis_tready, 0);
        check("full_count", fifo_count, 16);
        fork
            send(64'd16, 8'hFF, 1'b0, 1'b0, 64'd16);
            begin
                repeat (3) @(negedge clk);
                check("full_hold", s_axis_tready, 0);
                check("full_hold_count", fifo_count, 16);
                rd_mode = 3;
            end
        join
        idle();
        check("refill_count", fifo_count, 16);
        drain();

        streaming = 1'b1;
        max_cnt = 0;
        rd_mode = 1;
        for (int i = 0; i < 100; i++) send(64'h1000 + 64'(i), 8'hFF, 1'b0, 1'b1, 64'h1000 + 64'(i));
        idle();
        streaming = 1'b0;
        check("stream_max_count", (max_cnt <= 1), 1);
        drain();

        for (int i = 0; i < 5; i++) send(64'h2000 + 64'(i), 8'hFF, (i == 2), 1'b0, 64'h2000 + 64'(i));
        check("pre_reset_count", fifo_count, 5);
        reset = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        exp_q.delete();
        check("midrst_count", fifo_count, 0);
        check("midrst_empty_n", dout_isif_empty_n, 0);
        check("midrst_pkt", pkt_cnt, 0);
        check("midrst_data", dout_isif_data, 0);
        check("midrst_tready", s_axis_tready, 0);
        @(negedge clk);
        check("midrst_tready_held", s_axis_tready, 0);
        reset = 1'b0;
        idle();
        @(negedge clk);
        check("post_rst_tready", s_axis_tready, 1);
        check("post_rst_count", fifo_count, 0);

        rd_mode = 2;
        for (int i = 0; i < 40; i++) begin
            idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(64'hA000 + 64'(i), 8'hFF, (i % 8 == 7), 1'(i % 2), 64'hA000 + 64'(i));
        end
        idle();
        drain();
        check("wrap_pkt", pkt_cnt, 5);

        send(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, 1'b0,
`ifdef ISIF_STRB_MASK_EN
             64'h0000_0000_FFFF_FFFF);
`else
             64'hFFFF_FFFF_FFFF_FFFF);
`endif
        idle();
`ifdef ISIF_STRB_MASK_EN
        check("strb_data", dout_isif_data, 64'h0000_0000_FFFF_FFFF);
`else
        check("strb_data", dout_isif_data, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        check("strb_strb", dout_isif_strb, 8'h0F);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", chk, errs);
        $finish;
    end
endmodule
